// File: rtl/vm_pkg.sv
// Shared coin encoding, coin values and change-dispenser FSM states.
// The vending machine core uses the same coin_t encoding.
package vm_pkg;

  localparam int AMT_W = 16;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    NICKEL  = 2'b01,
    DIME    = 2'b10,
    QUARTER = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_DONE
  } chg_state_t;

  // Face value in cents of a coin code; NONE is worth nothing.
  function automatic logic [AMT_W-1:0] COIN_VALUE(input coin_t c);
    case (c)
      NICKEL:  return AMT_W'(5);
      DIME:    return AMT_W'(10);
      QUARTER: return AMT_W'(25);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Request, ejector, customer-coin, refill and status signals of the change
// dispenser. master = vending machine core / ejector side, slave = dispenser.
interface vm_change_dispenser_if #(
  parameter int TUBE_W = 8
);
  logic              req_valid;
  logic [15:0]       req_amount;
  logic              req_ready;
  logic              eject_valid;
  logic [1:0]        eject_coin;
  logic              eject_ack;
  logic              coin_in_valid;
  logic [1:0]        coin_in;
  logic              refill_valid;
  logic [1:0]        refill_coin;
  logic [TUBE_W-1:0] refill_count;
  logic              done;
  logic [15:0]       shortfall;
  logic              fault;
  logic [TUBE_W-1:0] tube_n;
  logic [TUBE_W-1:0] tube_d;
  logic [TUBE_W-1:0] tube_q;

  modport master (
    output req_valid, req_amount, eject_ack, coin_in_valid, coin_in,
           refill_valid, refill_coin, refill_count,
    input  req_ready, eject_valid, eject_coin, done, shortfall, fault,
           tube_n, tube_d, tube_q
  );

  modport slave (
    input  req_valid, req_amount, eject_ack, coin_in_valid, coin_in,
           refill_valid, refill_coin, refill_count,
    output req_ready, eject_valid, eject_coin, done, shortfall, fault,
           tube_n, tube_d, tube_q
  );
endinterface

// File: rtl/vm_coin_tube.sv
// One coin tube counter: +1 (customer coin), +N (refill), -1 (ejection),
// all possibly in the same cycle, result saturated to 0..TUBE_MAX.
module vm_coin_tube #(
  parameter int TUBE_MAX = 200,
  parameter int TUBE_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_one,
  input  logic [TUBE_W-1:0] inc_n,
  input  logic              dec_one,
  output logic [TUBE_W-1:0] count
);
  // Two extra bits hold count + N + 1 without wrapping.
  localparam int SUM_W = TUBE_W + 2;
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(TUBE_MAX);

  logic [TUBE_W-1:0] count_reg, count_next;
  logic [SUM_W-1:0]  sum_up, sum_net;

  // Combine all three sources first, then clamp once at both ends.
  always_comb begin
    sum_up     = SUM_W'(count_reg) + SUM_W'(inc_n) + SUM_W'(inc_one);
    sum_net    = sum_up - SUM_W'(dec_one);
    count_next = count_reg;
    if (dec_one && (sum_up == '0)) begin
      count_next = '0;
    end else if (sum_net > MAX_SUM) begin
      count_next = TUBE_W'(TUBE_MAX);
    end else begin
      count_next = sum_net[TUBE_W-1:0];
    end
  end

  // Tube count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/vm_change_dispenser.sv
// Change-return engine: splits a cent amount into quarter/dime/nickel
// ejections (largest first), one coin per ejector handshake, tracking tube
// inventory and reporting any unpayable remainder as shortfall.
// Optional build macro VM_CHG_TIMEOUT_EN adds an ejector ack timeout that
// aborts the request and raises a sticky fault.
module vm_change_dispenser #(
  parameter int TUBE_MAX    = 200,
  parameter int TUBE_W      = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                   clk,
  input logic                   rst,
  vm_change_dispenser_if.slave  bus
);
  import vm_pkg::*;

  chg_state_t        state_reg, state_next;
  logic [AMT_W-1:0]  remaining_reg;
  logic [AMT_W-1:0]  shortfall_reg;
  coin_t             eject_coin_reg;
  coin_t             pick;
  logic [1:0]        eject_code;
  logic              ack_take;
  logic              timeout_hit;
  logic [TUBE_W-1:0] tube_cnt [3];

  assign eject_code = eject_coin_reg;
  // Ack only counts while a coin is actually being offered.
  assign ack_take   = (state_reg == ST_EJECT) && bus.eject_ack;

  // Greedy coin choice: largest denomination that fits and is in stock.
  always_comb begin
    pick = NONE;
    if ((remaining_reg >= AMT_W'(25)) && (tube_cnt[2] != '0)) begin
      pick = QUARTER;
    end else if ((remaining_reg >= AMT_W'(10)) && (tube_cnt[1] != '0)) begin
      pick = DIME;
    end else if ((remaining_reg >= AMT_W'(5)) && (tube_cnt[0] != '0)) begin
      pick = NICKEL;
    end
  end

`ifdef VM_CHG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            fault_reg;

  // Counts EJECT cycles spent waiting; restarts for every coin.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg <= '0;
    end else if (state_reg != ST_EJECT) begin
      to_cnt_reg <= '0;
    end else if (!bus.eject_ack) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

  // The last waiting cycle without an ack gives up on the coin.
  assign timeout_hit = (state_reg == ST_EJECT) && !bus.eject_ack &&
                       (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  // Sticky fault: only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else if (timeout_hit) begin
      fault_reg <= 1'b1;
    end
  end

  assign bus.fault = fault_reg;
`else
  logic timeout_unused;

  // Timeout length is meaningless without the timeout logic.
  assign timeout_unused = (TIMEOUT_CYC != 0);
  assign timeout_hit    = 1'b0;
  assign bus.fault      = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.req_valid) state_next = ST_SELECT;
      ST_SELECT: state_next = (pick != NONE) ? ST_EJECT : ST_DONE;
      ST_EJECT: begin
        if (bus.eject_ack) begin
          state_next = ST_SELECT;
        end else if (timeout_hit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    bus.req_ready   = (state_reg == ST_IDLE);
    bus.eject_valid = (state_reg == ST_EJECT);
    bus.done        = (state_reg == ST_DONE);
  end

  // Amount bookkeeping and coin register.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_reg  <= '0;
      shortfall_reg  <= '0;
      eject_coin_reg <= NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid) begin
            remaining_reg <= bus.req_amount;
            shortfall_reg <= '0;
          end
        end
        ST_SELECT: begin
          eject_coin_reg <= pick;
          if (pick == NONE) begin
            shortfall_reg <= remaining_reg;
          end
        end
        ST_EJECT: begin
          if (ack_take) begin
            remaining_reg <= remaining_reg - COIN_VALUE(eject_coin_reg);
          end else if (timeout_hit) begin
            shortfall_reg <= remaining_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.eject_coin = eject_code;
  assign bus.shortfall  = shortfall_reg;

  // One tube per denomination; index gi holds coin code gi+1.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tube
      localparam logic [1:0] CODE = 2'(gi + 1);

      logic              inc_one;
      logic              dec_one;
      logic [TUBE_W-1:0] inc_n;

      assign inc_one = bus.coin_in_valid && (bus.coin_in == CODE);
      assign inc_n   = (bus.refill_valid && (bus.refill_coin == CODE)) ?
                       bus.refill_count : '0;
      assign dec_one = ack_take && (eject_code == CODE);

      vm_coin_tube #(
        .TUBE_MAX (TUBE_MAX),
        .TUBE_W   (TUBE_W)
      ) u_tube (
        .clk     (clk),
        .rst     (rst),
        .inc_one (inc_one),
        .inc_n   (inc_n),
        .dec_one (dec_one),
        .count   (tube_cnt[gi])
      );
    end
  endgenerate

  assign bus.tube_n = tube_cnt[0];
  assign bus.tube_d = tube_cnt[1];
  assign bus.tube_q = tube_cnt[2];

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Self-checking bench for vm_change_dispenser: directed scenarios plus
// randomized requests against a greedy change-making model of the tubes.
module tb_vm_change_dispenser;

`ifdef VM_CHG_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 1000;
`endif
  localparam int TMAX = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vm_change_dispenser_if #(.TUBE_W(8)) bus ();

  vm_change_dispenser #(
    .TUBE_MAX    (TMAX),
    .TUBE_W      (8),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int tube [4];                       // model tube counts by coin code
  int value_of [4] = '{0, 5, 10, 25}; // cents by coin code

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > TMAX) return TMAX;
    return v;
  endfunction

  // Largest coin that fits the remainder and is in the model tubes.
  function automatic int pick_coin(input int rem);
    if (rem >= 25 && tube[3] > 0) return 3;
    if (rem >= 10 && tube[2] > 0) return 2;
    if (rem >= 5  && tube[1] > 0) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid     = 1'b0;
    bus.req_amount    = 16'd0;
    bus.eject_ack     = 1'b0;
    bus.coin_in_valid = 1'b0;
    bus.coin_in       = 2'd0;
    bus.refill_valid  = 1'b0;
    bus.refill_coin   = 2'd0;
    bus.refill_count  = 8'd0;
  endtask

  task automatic check_tubes(input string tag);
    chk({tag, "_n"}, 32'(bus.tube_n), tube[1]);
    chk({tag, "_d"}, 32'(bus.tube_d), tube[2]);
    chk({tag, "_q"}, 32'(bus.tube_q), tube[3]);
  endtask

  // One reset cycle, then the full reset state is checked.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    for (int i = 0; i < 4; i++) tube[i] = 0;
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_eject_valid", 32'(bus.eject_valid), 0);
    chk("rst_eject_coin", 32'(bus.eject_coin), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_shortfall", 32'(bus.shortfall), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    check_tubes("rst_tube");
    rst = 1'b0;
  endtask

  task automatic refill(input int code, input int n);
    bus.refill_valid = 1'b1;
    bus.refill_coin  = 2'(code);
    bus.refill_count = 8'(n);
    tick();
    bus.refill_valid = 1'b0;
    tube[code] = clamp(tube[code] + n);
  endtask

  // Full request; cin_mode < 0 drops a random customer coin on each ack,
  // otherwise that fixed code (0 = none).
  task automatic run_request(input int amount, input int cin_mode);
    int rem, ncoins, c, d, cin;
    int delta [4];
    rem    = amount;
    ncoins = 0;
    bus.req_valid  = 1'b1;
    bus.req_amount = 16'(amount);
    tick();
    bus.req_valid = 1'b0;
    chk("accept_ready", 32'(bus.req_ready), 0);
    chk("accept_shortfall", 32'(bus.shortfall), 0);
    for (int step = 0; step < 50; step++) begin
      c = pick_coin(rem);
      if (c == 0) break;
      tick();
      chk("eject_valid", 32'(bus.eject_valid), 1);
      chk("eject_coin", 32'(bus.eject_coin), c);
      d = int'($urandom_range(0, 2));
      for (int h = 0; h < d; h++) begin
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_amount = 16'($urandom_range(0, 200));
        tick();
        chk("eject_hold_valid", 32'(bus.eject_valid), 1);
        chk("eject_hold_coin", 32'(bus.eject_coin), c);
      end
      bus.req_valid = 1'b0;
      cin = (cin_mode < 0) ? int'($urandom_range(0, 3)) : cin_mode;
      bus.eject_ack     = 1'b1;
      bus.coin_in_valid = (cin != 0);
      bus.coin_in       = 2'(cin);
      tick();
      bus.eject_ack     = 1'b0;
      bus.coin_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) delta[i] = 0;
      delta[c] -= 1;
      if (cin != 0) delta[cin] += 1;
      for (int i = 1; i < 4; i++) tube[i] = clamp(tube[i] + delta[i]);
      rem -= value_of[c];
      ncoins++;
      chk("post_ack_valid", 32'(bus.eject_valid), 0);
      check_tubes("post_ack_tube");
    end
    tick();
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_shortfall", 32'(bus.shortfall), rem);
    chk("done_not_ready", 32'(bus.req_ready), 0);
    tick();
    chk("done_cleared", 32'(bus.done), 0);
    chk("ready_back", 32'(bus.req_ready), 1);
    chk("shortfall_held", 32'(bus.shortfall), rem);
    $display("req amount=%0d coins=%0d shortfall=%0d tubes n=%0d d=%0d q=%0d",
             amount, ncoins, rem, tube[1], tube[2], tube[3]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    do_reset();

    // Q=4 D=4 N=4, request 40 -> Q, D, N, shortfall 0.
    refill(3, 4); refill(2, 4); refill(1, 4);
    check_tubes("refill_tube");
    run_request(40, 0);
    chk("t1_n", 32'(bus.tube_n), 3);
    chk("t1_d", 32'(bus.tube_d), 3);
    chk("t1_q", 32'(bus.tube_q), 3);

    // No quarters: 30 -> three dimes.
    do_reset();
    refill(2, 5); refill(1, 5);
    run_request(30, 0);
    chk("t2_d", 32'(bus.tube_d), 2);

    // 7 cents -> one nickel, shortfall 2.
    do_reset();
    refill(1, 10); refill(2, 10); refill(3, 10);
    run_request(7, 0);
    chk("t3_shortfall", 32'(bus.shortfall), 2);

    // Zero request and request with nothing to pay from.
    run_request(0, 0);
    do_reset();
    run_request(35, 0);

    // Saturation with refill, customer coin and ejection together.
    do_reset();
    refill(2, 199);
    chk("sat_199", 32'(bus.tube_d), 199);
    bus.refill_valid  = 1'b1;
    bus.refill_coin   = 2'd2;
    bus.refill_count  = 8'd5;
    bus.coin_in_valid = 1'b1;
    bus.coin_in       = 2'd2;
    tick();
    idle_inputs();
    tube[2] = clamp(199 + 5 + 1);
    chk("sat_200", 32'(bus.tube_d), 200);
    run_request(10, 2);
    chk("sat_eject_in", 32'(bus.tube_d), 200);

    // Reset in the middle of EJECT with ack withheld.
    do_reset();
    refill(2, 3);
    bus.req_valid  = 1'b1;
    bus.req_amount = 16'd10;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(bus.eject_valid), 1);
    do_reset();

    // Ack strobe without an offered coin must not touch the tubes.
    refill(1, 2);
    bus.eject_ack = 1'b1;
    tick();
    bus.eject_ack = 1'b0;
    tick();
    check_tubes("stray_ack_tube");

`ifdef VM_CHG_TIMEOUT_EN
    // Ack never arrives: 8 EJECT cycles, then fault and full shortfall.
    do_reset();
    refill(3, 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = 16'd25;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("to_valid_1", 32'(bus.eject_valid), 1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("to_waiting_valid", 32'(bus.eject_valid), 1);
      chk("to_waiting_fault", 32'(bus.fault), 0);
    end
    tick();
    chk("to_valid_dropped", 32'(bus.eject_valid), 0);
    chk("to_fault", 32'(bus.fault), 1);
    chk("to_done", 32'(bus.done), 1);
    chk("to_shortfall", 32'(bus.shortfall), 25);
    chk("to_tube_q", 32'(bus.tube_q), 1);
    tick();
    chk("to_ready", 32'(bus.req_ready), 1);
    chk("to_fault_sticky", 32'(bus.fault), 1);
    $display("req amount=25 timeout shortfall=%0d fault=%0d",
             bus.shortfall, bus.fault);
`endif

    // Randomized requests against the greedy model.
    do_reset();
    for (int it = 0; it < 20; it++) begin
      for (int code = 1; code < 4; code++) begin
        refill(code, int'($urandom_range(0, 4)));
      end
      run_request(int'($urandom_range(0, 130)), -1);
    end
    check_tubes("final_tube");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm_change_dispenser.md
# vm_change_dispenser

Change-return engine on the output side of the vending machine. It accepts a refund/change amount in cents from the vending machine core and breaks it into nickel, dime and quarter ejections, largest coin first. It tracks per-denomination coin tube inventory, driving a coin-ejector handshake one coin at a time. Any amount it cannot pay is reported back as a shortfall.

## Interface
- `TUBE_MAX`, default 200: saturation limit of each coin tube count.
- `TUBE_W`, default 8: width of each tube counter.
- `TIMEOUT_CYC`, default 1000: cycles to wait for an ejector ack. Used only with `VM_CHG_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: change request valid.
- `req_amount` in 16: amount to return, in cents.
- `req_ready` out 1: high only in IDLE.
- `eject_valid` out 1: coin ejection request.
- `eject_coin` out 2: coin code to eject.
- `eject_ack` in 1: ejector confirms the coin has dropped.
- `coin_in_valid` in 1: the vending machine accepted a customer coin.
- `coin_in` in 2: coin code of the accepted customer coin.
- `refill_valid` in 1: service refill strobe.
- `refill_coin` in 2: coin code being refilled.
- `refill_count` in TUBE_W: number of coins added by the refill.
- `done` out 1: one-cycle pulse when a request completes.
- `shortfall` out 16: unpaid cents; valid while `done` is high and held until the next accept.
- `fault` out 1: sticky ack-timeout flag. Tied to 0 without the macro.
- `tube_n`, `tube_d`, `tube_q` out TUBE_W each: current tube counts.

## Operation
- Coin codes: 00 = none, 01 = nickel (5), 10 = dime (10), 11 = quarter (25).
- Reset values:
  - State = IDLE; `req_ready` = 1.
  - `eject_valid` = 0, `eject_coin` = 00, `done` = 0, `shortfall` = 0, `fault` = 0.
  - All tubes = 0; the internal `remaining` register = 0.
- States: IDLE, SELECT, EJECT, DONE.
- IDLE: on `req_valid` && `req_ready`:
  - load `remaining` = `req_amount`;
  - clear `shortfall`;
  - go to SELECT.
- SELECT picks the first coin in the order Q, D, N that satisfies value ≤ `remaining` and tube > 0.
  - If a coin is found, register it on `eject_coin` and go to EJECT.
  - Otherwise set `shortfall` = `remaining` and go to DONE. This covers `remaining` = 0, a remainder below 5, and empty tubes.
- EJECT:
  - Hold `eject_valid` = 1 with `eject_coin` stable until `eject_ack`.
  - On ack, decrement that coin's tube, subtract its value from `remaining`, and go to SELECT.
- DONE: pulse `done` for one cycle, then go to IDLE.
- Tube update each cycle is tube + refill + coin_in − ejected, saturated to the range 0..TUBE_MAX. All three sources may hit the same denomination in the same cycle.
- A request with `req_amount` = 0 completes as IDLE → SELECT → DONE with shortfall 0.
- `req_valid` outside IDLE is ignored; there is no queueing.
- `eject_ack` while `eject_valid` = 0 is ignored.
- `rst` in any state aborts the operation and restores all reset values, including the tubes. A coin in flight is forgotten.

## Timing
- Accept-to-first-`eject_valid` latency: 2 cycles (IDLE → SELECT → EJECT).
- Per coin: SELECT takes 1 cycle; EJECT takes at least 1 cycle, ending with the ack cycle.
- An ack in the same cycle `eject_valid` rises is legal. The tube decrement is visible the following cycle.
- `done` asserts the cycle after the last SELECT. `req_ready` returns the cycle after `done`.
- Tube count outputs are registered and reflect all updates one cycle later.

## Configuration
- `VM_CHG_TIMEOUT_EN` defined:
  - EJECT counts cycles without an ack.
  - At TIMEOUT_CYC the block drops `eject_valid`, sets `fault`, and sets `shortfall` = `remaining`; the tube is not decremented.
  - It then goes to DONE.
  - `fault` clears only on `rst`.
- `VM_CHG_TIMEOUT_EN` undefined: EJECT waits indefinitely, `fault` is constant 0, and no counter is present.

## Structure
- Package `vm_pkg` holds:
  - the `coin_t` enum (NONE/NICKEL/DIME/QUARTER);
  - the `COIN_VALUE` function;
  - the `chg_state_t` FSM enum.
- The vending machine core shares the same coin encoding.
- Sub-module `vm_coin_tube`: one saturating counter per denomination, with inc-by-1, inc-by-N and dec-by-1 inputs. It is instantiated three times.

## Test plan
- Tubes Q = 4, D = 4, N = 4; request 40 → ejects Q, D, N in that order; `done` with shortfall 0; tubes end 3/3/3.
- Tubes Q = 0, D = 5, N = 5; request 30 → D, D, D; shortfall 0; D tube = 2.
- Tubes all 10; request 7 → N only; shortfall 2.
- D tube = 199:
  - refill D with count 5 and `coin_in` D in the same cycle → D = 200 (saturated);
  - next cycle, D ejected with ack plus `coin_in` D → D = 200.
- Assert `rst` during EJECT with ack withheld → next cycle IDLE, `eject_valid` = 0, tubes = 0, `req_ready` = 1.
- With `VM_CHG_TIMEOUT_EN`, TIMEOUT_CYC = 8; tubes Q = 1; request 25 with ack never given → after 8 EJECT cycles `fault` = 1 and `done` with shortfall 25; Q tube stays 1.
